// File: rtl/step0_reorder.sv
// Reorders first-stage butterfly results: add half passes through, sub half is buffered then drained with -j on the upper beats.
// Latency: one cycle from an accepted input beat to its output; buffered sub beats follow the 16 add beats contiguously.
// No backpressure: input arriving during the drain is dropped and flagged by a one-cycle overrun pulse.
module step0_reorder #(
  parameter int DATA_WIDTH = 10,
  parameter int PAR        = 16,
  parameter int BLK_BEATS  = 16,
  parameter int ROT_START  = 8
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             din_valid,
  input  logic [PAR-1:0][DATA_WIDTH-1:0]   din_add_r,
  input  logic [PAR-1:0][DATA_WIDTH-1:0]   din_add_i,
  input  logic [PAR-1:0][DATA_WIDTH-1:0]   din_sub_r,
  input  logic [PAR-1:0][DATA_WIDTH-1:0]   din_sub_i,
  output logic                             dout_valid,
  output logic [PAR-1:0][DATA_WIDTH-1:0]   dout_i,
  output logic [PAR-1:0][DATA_WIDTH-1:0]   dout_q,
  output logic                             blk_start,
  output logic                             overrun
);

  localparam int CW = $clog2(BLK_BEATS);

  typedef logic [PAR-1:0][DATA_WIDTH-1:0] lane_vec_t;
  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  lane_vec_t     sub_r_mem [BLK_BEATS];
  lane_vec_t     sub_i_mem [BLK_BEATS];
  lane_vec_t     drain_i, drain_q;
  logic          accept;
  logic          last_beat;

  // IDLE behaves as PASS beat 0, so any non-DRAIN state takes the beat
  assign accept    = din_valid && (state != DRAIN);
  assign last_beat = (cnt == CW'(BLK_BEATS - 1));

  // Two's-complement negate; the most negative code has no positive twin, so clamp it
  function automatic logic [DATA_WIDTH-1:0] neg_sat(input logic [DATA_WIDTH-1:0] x);
    if (x == {1'b1, {(DATA_WIDTH-1){1'b0}}})
      neg_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else
      neg_sat = -x;
  endfunction

  // Next-state and beat counter: PASS advances only on valid beats, DRAIN advances every cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, PASS: begin
        if (din_valid) begin
          cnt_nxt   = last_beat ? '0 : cnt + CW'(1);
          state_nxt = last_beat ? DRAIN : PASS;
        end
      end
      DRAIN: begin
        cnt_nxt   = last_beat ? '0 : cnt + CW'(1);
        state_nxt = last_beat ? IDLE : DRAIN;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Drain beat selection: upper beats get the -j rotation (r + j i) -> (i - j r)
  always_comb begin
    drain_i = sub_r_mem[cnt];
    drain_q = sub_i_mem[cnt];
    if (cnt >= CW'(ROT_START)) begin
      for (int l = 0; l < PAR; l++) begin
        drain_i[l] = sub_i_mem[cnt][l];
        drain_q[l] = neg_sat(sub_r_mem[cnt][l]);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Sub-half buffer; contents are meaningless after reset so it is left unreset
  always_ff @(posedge clk) begin
    if (accept) begin
      sub_r_mem[cnt] <= din_sub_r;
      sub_i_mem[cnt] <= din_sub_i;
    end
  end

  // Registered output beat: drain data, pass-through add data, or hold with valid low
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_valid <= 1'b0;
      dout_i     <= '0;
      dout_q     <= '0;
      blk_start  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun   <= din_valid && (state == DRAIN);
      blk_start <= accept && (cnt == '0);
      if (state == DRAIN) begin
        dout_valid <= 1'b1;
        dout_i     <= drain_i;
        dout_q     <= drain_q;
      end else if (din_valid) begin
        dout_valid <= 1'b1;
        dout_i     <= din_add_r;
        dout_q     <= din_add_i;
      end else begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_step0_reorder.sv
// Directed bench for step0_reorder: one task per scenario, inline comparisons.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Output observed after the edge that captured input cycle c is the response to cycle c.
module tb_step0_reorder;

  localparam int DW  = 10;
  localparam int PAR = 16;

  typedef logic [PAR-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic din_valid = 1'b0;
  vec_t din_add_r = '0;
  vec_t din_add_i = '0;
  vec_t din_sub_r = '0;
  vec_t din_sub_i = '0;
  logic dout_valid;
  vec_t dout_i;
  vec_t dout_q;
  logic blk_start;
  logic overrun;

  int checks = 0;
  int passes = 0;
  bit sat = 1'b0;

  always #5 clk = ~clk;

  step0_reorder dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid),
    .din_add_r(din_add_r), .din_add_i(din_add_i),
    .din_sub_r(din_sub_r), .din_sub_i(din_sub_i),
    .dout_valid(dout_valid), .dout_i(dout_i), .dout_q(dout_q),
    .blk_start(blk_start), .overrun(overrun)
  );

  // ---------------- stimulus / expected-value generators ----------------
  function automatic vec_t f_add_r(int b);
    vec_t v;
    for (int k = 0; k < PAR; k++) v[k] = DW'(b * 16 + k);
    return v;
  endfunction

  function automatic vec_t f_add_i(int b);
    vec_t v;
    for (int k = 0; k < PAR; k++) v[k] = DW'(-(b * 16 + k));
    return v;
  endfunction

  function automatic int sub_re(int b, int k);
    if (sat && b == 12 && k == 0) return -512;
    if (sat && b == 13 && k == 3) return 511;
    return b + 1;
  endfunction

  function automatic int sub_im(int b, int k);
    if (sat && b == 12 && k == 0) return 100;
    if (sat && b == 13 && k == 3) return -5;
    return 2 * b;
  endfunction

  function automatic vec_t f_sub_r(int b);
    vec_t v;
    for (int k = 0; k < PAR; k++) v[k] = DW'(sub_re(b, k));
    return v;
  endfunction

  function automatic vec_t f_sub_i(int b);
    vec_t v;
    for (int k = 0; k < PAR; k++) v[k] = DW'(sub_im(b, k));
    return v;
  endfunction

  // Expected drain output, in-phase part: beats 0..7 unchanged, 8..15 take the imaginary part
  function automatic vec_t f_exp_i(int d);
    vec_t v;
    for (int k = 0; k < PAR; k++) v[k] = DW'((d < 8) ? sub_re(d, k) : sub_im(d, k));
    return v;
  endfunction

  // Expected drain output, quadrature part: beats 8..15 take the saturated negated real part
  function automatic vec_t f_exp_q(int d);
    vec_t v;
    int n;
    for (int k = 0; k < PAR; k++) begin
      if (d < 8) n = sub_im(d, k);
      else begin
        n = -sub_re(d, k);
        if (n > 511) n = 511;
      end
      v[k] = DW'(n);
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int b, input bit v);
    din_valid = v;
    if (v) begin
      din_add_r = f_add_r(b);
      din_add_i = f_add_i(b);
      din_sub_r = f_sub_r(b);
      din_sub_i = f_sub_i(b);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if ({dout_valid, blk_start, overrun} !== 3'b000) $display("FAIL reset_flags got %b required 000", {dout_valid, blk_start, overrun});
    else passes++;
    checks++;
    if (dout_i !== '0) $display("FAIL reset_dout_i got %h required 0", dout_i);
    else passes++;
    checks++;
    if (dout_q !== '0) $display("FAIL reset_dout_q got %h required 0", dout_q);
    else passes++;
  endtask

  task automatic test_single_block(input bit s);
    int nvalid;
    vec_t ei, eq;
    sat = s;
    nvalid = 0;
    for (int cyc = 0; cyc < 34; cyc++) begin
      drive(cyc, cyc < 16);
      tick();
      if (dout_valid === 1'b1) nvalid++;
      checks++;
      if (dout_valid !== (cyc < 32)) $display("FAIL single_valid cyc=%0d got %b required %b", cyc, dout_valid, cyc < 32);
      else passes++;
      checks++;
      if (blk_start !== (cyc == 0)) $display("FAIL single_blk_start cyc=%0d got %b required %b", cyc, blk_start, cyc == 0);
      else passes++;
      checks++;
      if (overrun !== 1'b0) $display("FAIL single_overrun cyc=%0d got %b required 0", cyc, overrun);
      else passes++;
      if (cyc < 32) begin
        ei = (cyc < 16) ? f_add_r(cyc) : f_exp_i(cyc - 16);
        eq = (cyc < 16) ? f_add_i(cyc) : f_exp_q(cyc - 16);
        checks++;
        if (dout_i !== ei || dout_q !== eq)
          $display("FAIL single_data sat=%0d cyc=%0d got i=%h q=%h required i=%h q=%h", s, cyc, dout_i, dout_q, ei, eq);
        else passes++;
      end
    end
    checks++;
    if (nvalid != 32) $display("FAIL single_valid_count got %0d required 32", nvalid);
    else passes++;
    sat = 1'b0;
  endtask

  task automatic test_saturation();
    test_single_block(1'b1);
  endtask

  task automatic test_gapped();
    vec_t ei, eq;
    bit ev;
    for (int cyc = 0; cyc < 49; cyc++) begin
      drive(cyc / 2, (cyc < 32) && (cyc % 2 == 0));
      tick();
      ev = (cyc < 31) ? (cyc % 2 == 0) : (cyc < 47);
      checks++;
      if (dout_valid !== ev) $display("FAIL gapped_valid cyc=%0d got %b required %b", cyc, dout_valid, ev);
      else passes++;
      checks++;
      if (blk_start !== (cyc == 0)) $display("FAIL gapped_blk_start cyc=%0d got %b required %b", cyc, blk_start, cyc == 0);
      else passes++;
      if (cyc < 47) begin
        // In gaps the output holds the previous add beat
        ei = (cyc < 31) ? f_add_r(cyc / 2) : f_exp_i(cyc - 31);
        eq = (cyc < 31) ? f_add_i(cyc / 2) : f_exp_q(cyc - 31);
        checks++;
        if (dout_i !== ei || dout_q !== eq)
          $display("FAIL gapped_data cyc=%0d got i=%h q=%h required i=%h q=%h", cyc, dout_i, dout_q, ei, eq);
        else passes++;
      end
    end
  endtask

  task automatic test_overrun();
    vec_t ei, eq;
    for (int cyc = 0; cyc < 34; cyc++) begin
      drive((cyc < 16) ? cyc : 3, (cyc < 16) || (cyc == 21));
      tick();
      checks++;
      if (overrun !== (cyc == 21)) $display("FAIL overrun_pulse cyc=%0d got %b required %b", cyc, overrun, cyc == 21);
      else passes++;
      checks++;
      if (dout_valid !== (cyc < 32)) $display("FAIL overrun_valid cyc=%0d got %b required %b", cyc, dout_valid, cyc < 32);
      else passes++;
      if (cyc < 32) begin
        ei = (cyc < 16) ? f_add_r(cyc) : f_exp_i(cyc - 16);
        eq = (cyc < 16) ? f_add_i(cyc) : f_exp_q(cyc - 16);
        checks++;
        if (dout_i !== ei || dout_q !== eq)
          $display("FAIL overrun_data cyc=%0d got i=%h q=%h required i=%h q=%h", cyc, dout_i, dout_q, ei, eq);
        else passes++;
      end
    end
    test_single_block(1'b0);
  endtask

  task automatic test_back_to_back();
    int nvalid;
    int p;
    vec_t ei, eq;
    nvalid = 0;
    for (int cyc = 0; cyc < 67; cyc++) begin
      p = cyc % 32;
      drive(p, (cyc < 64) && (p < 16));
      tick();
      if (dout_valid === 1'b1) nvalid++;
      checks++;
      if (dout_valid !== (cyc < 64)) $display("FAIL b2b_valid cyc=%0d got %b required %b", cyc, dout_valid, cyc < 64);
      else passes++;
      checks++;
      if (blk_start !== (cyc == 0 || cyc == 32)) $display("FAIL b2b_blk_start cyc=%0d got %b required %b", cyc, blk_start, cyc == 0 || cyc == 32);
      else passes++;
      checks++;
      if (overrun !== 1'b0) $display("FAIL b2b_overrun cyc=%0d got %b required 0", cyc, overrun);
      else passes++;
      if (cyc < 64) begin
        ei = (p < 16) ? f_add_r(p) : f_exp_i(p - 16);
        eq = (p < 16) ? f_add_i(p) : f_exp_q(p - 16);
        checks++;
        if (dout_i !== ei || dout_q !== eq)
          $display("FAIL b2b_data cyc=%0d got i=%h q=%h required i=%h q=%h", cyc, dout_i, dout_q, ei, eq);
        else passes++;
      end
    end
    checks++;
    if (nvalid != 64) $display("FAIL b2b_valid_count got %0d required 64", nvalid);
    else passes++;
  endtask

  task automatic test_reset_mid_drain();
    for (int cyc = 0; cyc < 19; cyc++) begin
      drive(cyc, cyc < 16);
      tick();
    end
    // Now in DRAIN cycle 3: reset takes effect without waiting for an edge
    drive(0, 1'b0);
    rstn = 1'b0;
    #1;
    checks++;
    if ({dout_valid, blk_start, overrun} !== 3'b000) $display("FAIL midrst_flags got %b required 000", {dout_valid, blk_start, overrun});
    else passes++;
    checks++;
    if (dout_i !== '0 || dout_q !== '0) $display("FAIL midrst_data got i=%h q=%h required 0", dout_i, dout_q);
    else passes++;
    tick();
    tick();
    checks++;
    if ({dout_valid, blk_start, overrun} !== 3'b000 || dout_i !== '0 || dout_q !== '0)
      $display("FAIL midrst_held got flags=%b i=%h q=%h required all 0", {dout_valid, blk_start, overrun}, dout_i, dout_q);
    else passes++;
    rstn = 1'b1;
    tick();
    test_single_block(1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    drive(0, 1'b0);
    tick();
    tick();
    test_reset();
    rstn = 1'b1;
    tick();
    test_single_block(1'b0);
    test_saturation();
    test_gapped();
    test_overrun();
    test_back_to_back();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
